// File: rtl/universal_shift_reg_param_if.sv
// ============================================================================
// Module   : universal_shift_reg_param_if
// Brief    : Control, data and status bundle for the universal shift register.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

interface universal_shift_reg_param_if #(
  parameter int WIDTH = 8,
  parameter int CNT_W = 4
);
  logic             en_i;
  logic [2:0]       mode_i;
  logic             sin_lo_i;
  logic             sin_hi_i;
  logic [WIDTH-1:0] pin_i;
  logic             start_i;
  logic [CNT_W-1:0] len_i;
  logic [WIDTH-1:0] pout_o;
  logic             sout_lo_o;
  logic             sout_hi_o;
  logic             busy_o;
  logic             done_o;

  modport slave (
    input  en_i, mode_i, sin_lo_i, sin_hi_i, pin_i, start_i, len_i,
    output pout_o, sout_lo_o, sout_hi_o, busy_o, done_o
  );

  modport master (
    output en_i, mode_i, sin_lo_i, sin_hi_i, pin_i, start_i, len_i,
    input  pout_o, sout_lo_o, sout_hi_o, busy_o, done_o
  );
endinterface

`default_nettype wire

// File: rtl/universal_shift_reg_param.sv
// ============================================================================
// Module   : universal_shift_reg_param
// Brief    : WIDTH-bit universal shift register, eight modes, burst repeater.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module universal_shift_reg_param #(
  parameter int WIDTH = 8,
  parameter int CNT_W = 4
) (
  input  logic                        clk,
  input  logic                        rst_n,
  universal_shift_reg_param_if.slave  bus
);

  localparam logic [2:0] c_MODE_HOLD = 3'b000;
  localparam logic [2:0] c_MODE_SHU  = 3'b001;
  localparam logic [2:0] c_MODE_SHD  = 3'b010;
  localparam logic [2:0] c_MODE_LOAD = 3'b011;
  localparam logic [2:0] c_MODE_ROU  = 3'b100;
  localparam logic [2:0] c_MODE_ROD  = 3'b101;
  localparam logic [2:0] c_MODE_ASD  = 3'b110;
  localparam logic [2:0] c_MODE_CLR  = 3'b111;

  localparam logic [CNT_W-1:0] c_CNT_ZERO = '0;
  localparam logic [CNT_W-1:0] c_CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } state_t;

  state_t           r_state;
  state_t           w_state_nxt;
  logic [2:0]       r_mode;
  logic [2:0]       w_mode_nxt;
  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] w_cnt_nxt;
  logic             r_done;
  logic             w_done_nxt;
  logic [WIDTH-1:0] r_q;
  logic [WIDTH-1:0] w_q_nxt;
  logic             r_sout_lo;
  logic             r_sout_hi;
  logic             w_sout_lo_nxt;
  logic             w_sout_hi_nxt;
  logic             w_apply;
  logic [2:0]       w_op;

  // Sequencer: decides whether an op happens this edge and which one.
  always_comb begin
    w_state_nxt = r_state;
    w_mode_nxt  = r_mode;
    w_cnt_nxt   = r_cnt;
    w_done_nxt  = 1'b0;
    w_apply     = 1'b0;
    w_op        = bus.mode_i;
    case (r_state)
      ST_IDLE: begin
        if (bus.start_i) begin
          if (bus.len_i != c_CNT_ZERO) begin
            w_state_nxt = ST_RUN;
            w_mode_nxt  = bus.mode_i;
            w_cnt_nxt   = bus.len_i;
          end else begin
            w_done_nxt  = 1'b1;
          end
        end else if (bus.en_i) begin
          w_apply = 1'b1;
        end
      end
      ST_RUN: begin
        w_apply   = 1'b1;
        w_op      = r_mode;
        w_cnt_nxt = r_cnt - c_CNT_ONE;
        if (r_cnt == c_CNT_ONE) begin
          w_state_nxt = ST_IDLE;
          w_done_nxt  = 1'b1;
        end
      end
      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  // Datapath: serial-out flags only move on ops of their own direction or clear.
  always_comb begin
    w_q_nxt       = r_q;
    w_sout_lo_nxt = r_sout_lo;
    w_sout_hi_nxt = r_sout_hi;
    if (w_apply) begin
      case (w_op)
        c_MODE_HOLD: begin
          w_q_nxt = r_q;
        end
        c_MODE_SHU: begin
          w_q_nxt       = {r_q[WIDTH-2:0], bus.sin_lo_i};
          w_sout_hi_nxt = r_q[WIDTH-1];
        end
        c_MODE_SHD: begin
          w_q_nxt       = {bus.sin_hi_i, r_q[WIDTH-1:1]};
          w_sout_lo_nxt = r_q[0];
        end
        c_MODE_LOAD: begin
          w_q_nxt = bus.pin_i;
        end
        c_MODE_ROU: begin
          w_q_nxt       = {r_q[WIDTH-2:0], r_q[WIDTH-1]};
          w_sout_hi_nxt = r_q[WIDTH-1];
        end
        c_MODE_ROD: begin
          w_q_nxt       = {r_q[0], r_q[WIDTH-1:1]};
          w_sout_lo_nxt = r_q[0];
        end
        c_MODE_ASD: begin
          w_q_nxt       = {r_q[WIDTH-1], r_q[WIDTH-1:1]};
          w_sout_lo_nxt = r_q[0];
        end
        c_MODE_CLR: begin
          w_q_nxt       = '0;
          w_sout_lo_nxt = 1'b0;
          w_sout_hi_nxt = 1'b0;
        end
        default: begin
          w_q_nxt = r_q;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= ST_IDLE;
      r_mode    <= c_MODE_HOLD;
      r_cnt     <= c_CNT_ZERO;
      r_done    <= 1'b0;
      r_q       <= '0;
      r_sout_lo <= 1'b0;
      r_sout_hi <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_mode    <= w_mode_nxt;
      r_cnt     <= w_cnt_nxt;
      r_done    <= w_done_nxt;
      r_q       <= w_q_nxt;
      r_sout_lo <= w_sout_lo_nxt;
      r_sout_hi <= w_sout_hi_nxt;
    end
  end

  assign bus.pout_o    = r_q;
  assign bus.sout_lo_o = r_sout_lo;
  assign bus.sout_hi_o = r_sout_hi;
  assign bus.busy_o    = (r_state == ST_RUN);
  assign bus.done_o    = r_done;

endmodule

`default_nettype wire

// File: doc/universal_shift_reg_param.md
# universal_shift_reg_param

Parametrised universal shift register with WIDTH-bit storage, eight operation modes (hold, shift, rotate, arithmetic shift, load, clear) and an autonomous burst engine that repeats one operation a programmed number of times. It is the next-generation replacement for the fixed 4-bit, 4-mode shift register. It serves as the general serial/parallel conversion and bit-manipulation element of the design.

## Interface
- WIDTH, 8, register width in bits (>= 2)
- CNT_W, 4, width of burst length; max burst 2^CNT_W-1 operations

- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- en_i  input  1  apply mode_i once this cycle (idle only)
- mode_i  input  3  operation select (see Operation)
- sin_lo_i  input  1  serial bit entering bit 0 on shift-up
- sin_hi_i  input  1  serial bit entering bit WIDTH-1 on logical shift-down
- pin_i  input  WIDTH  parallel load data
- start_i  input  1  start burst (idle only)
- len_i  input  CNT_W  burst length in operations
- pout_o  output  WIDTH  register contents
- sout_lo_o  output  1  last bit leaving bit 0
- sout_hi_o  output  1  last bit leaving bit WIDTH-1
- busy_o  output  1  burst in progress
- done_o  output  1  one-cycle burst-complete pulse

## Operation
- Modes (q = register, ops applied at clock edge):
  - 000 hold: no change.
  - 001 shift up: q <= {q[W-2:0], sin_lo_i}; sout_hi_o <= q[W-1].
  - 010 shift down: q <= {sin_hi_i, q[W-1:1]}; sout_lo_o <= q[0].
  - 011 load: q <= pin_i.
  - 100 rotate up: q <= {q[W-2:0], q[W-1]}; sout_hi_o <= q[W-1].
  - 101 rotate down: q <= {q[0], q[W-1:1]}; sout_lo_o <= q[0].
  - 110 arithmetic shift down: q <= {q[W-1], q[W-1:1]}; sout_lo_o <= q[0].
  - 111 clear: q <= 0; sout_lo_o <= 0; sout_hi_o <= 0.
- sout_* change only on ops of their direction or clear; otherwise hold.
- State machine: IDLE, RUN.
  - IDLE, start_i=1, len_i=L>0: latch mode_i into mode_q and load cnt <= L. Go to RUN. No op at this edge; en_i is ignored.
  - IDLE, start_i=1, len_i=0: stay IDLE, no op, done_o=1 next cycle.
  - IDLE, start_i=0, en_i=1: apply mode_i once.
  - RUN: each edge applies mode_q and decrements cnt. sin_lo_i, sin_hi_i and pin_i are sampled live each cycle. When the applied op is the one with cnt==1, go to IDLE and assert done_o for the following cycle.
  - RUN ignores en_i, start_i, mode_i and len_i.
- start_i has priority over en_i in IDLE.

## Timing
- Reset (async assert, output effect immediate): pout_o=0, sout_lo_o=0, sout_hi_o=0, busy_o=0, done_o=0, state IDLE, cnt=0. Reset during RUN aborts the burst with no done_o.
- Single op: result visible on pout_o one cycle after en_i is sampled.
- Burst of L: start sampled at edge 0. busy_o is high after edges 0..L-1 (exactly L cycles) and ops occur at edges 1..L. At edge L, busy_o falls and done_o rises; done_o falls at edge L+1.
- A new start_i is accepted in the cycle done_o is high, which allows back-to-back bursts.
- All outputs are registered; no combinational input-to-output paths.

## Test plan
- Reset: hold rst_n=0 mid-cycle -> all outputs 0 immediately; release and stay idle -> values unchanged.
- Single ops, WIDTH=8, starting from load 0xA5 each time:
  - shift up, sin_lo=1 -> 0x4B, sout_hi=1.
  - shift down, sin_hi=0 -> 0x52, sout_lo=1.
  - arithmetic shift down -> 0xD2.
  - rotate up -> 0x4B.
  - rotate down -> 0xD2.
  - clear -> 0x00 with both sout=0.
- Burst: from 0x00, start shift-up, len=3, sin_lo=1 -> busy high 3 cycles, pout 0x01/0x03/0x07, done pulse 1 cycle; en_i and start_i toggled during busy have no effect.
- Zero-length and back-to-back: start len=0 -> done next cycle, busy never high, pout unchanged. Start len=2 on the done cycle -> second burst runs immediately.
- Max burst: rotate up 0x01 with len=15 (CNT_W=4) -> final 0x80, sout_hi=0, busy 15 cycles.
- Reset mid-burst: assert rst_n=0 on the 2nd busy cycle of a len=5 burst -> outputs 0, no done_o; a new burst after release behaves normally.
